serial_fifo_bridge: RTL and testbench

// - Buffers bytes between the CPU bus and ext_serial_controller: RX FIFO + TX FIFO, each a first-word-fall-through ring.
// - Drains received bytes from the controller (read_op/mode[1]) into the RX FIFO.
// - Feeds queued TX bytes to the controller (write_op/mode[0]), so the CPU never polls UART busy/ready directly.

---
 rtl/serial_fifo_bridge_if.sv | 36 +++
 rtl/serial_fifo_bridge.sv | 175 +++++++++++++++++
 tb/tb_serial_fifo_bridge.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_fifo_bridge_if.sv
// Bus bundle for serial_fifo_bridge: CPU-side FIFO access plus the serial controller handshake.
// The slave modport is the bridge; the master modport is whoever drives the CPU and controller sides.
interface serial_fifo_bridge_if #(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
);
  localparam int unsigned RxCw = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TxCw = $clog2(TX_DEPTH) + 1;

  logic            cpu_rx_pop;
  logic [7:0]      cpu_rx_data;
  logic            cpu_rx_valid;
  logic            cpu_tx_push;
  logic [7:0]      cpu_tx_data;
  logic            cpu_tx_ready;
  logic [RxCw-1:0] rx_count;
  logic [TxCw-1:0] tx_count;
  logic            rx_overrun;
  logic            ser_read_op;
  logic            ser_write_op;
  logic [7:0]      ser_data_write;
  logic [7:0]      ser_data_read;
  logic [1:0]      ser_mode;

  modport slave (
    input  cpu_rx_pop, cpu_tx_push, cpu_tx_data, ser_data_read, ser_mode,
    output cpu_rx_data, cpu_rx_valid, cpu_tx_ready, rx_count, tx_count, rx_overrun,
           ser_read_op, ser_write_op, ser_data_write
  );

  modport master (
    output cpu_rx_pop, cpu_tx_push, cpu_tx_data, ser_data_read, ser_mode,
    input  cpu_rx_data, cpu_rx_valid, cpu_tx_ready, rx_count, tx_count, rx_overrun,
           ser_read_op, ser_write_op, ser_data_write
  );
endinterface

// File: rtl/serial_fifo_bridge.sv
// RX/TX byte FIFOs (first-word-fall-through) between the CPU and a serial controller.
// Define SERIAL_FIFO_OVERRUN_EN to drop bytes on RX full and flag rx_overrun instead of stalling.
module serial_fifo_bridge #(
  parameter int unsigned RX_DEPTH     = 16,
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_fifo_bridge_if.slave bus
);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned RxCw = RxAw + 1;
  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned TxCw = TxAw + 1;
  localparam int unsigned TmrW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [2:0] {RxIdle, RxIssue, RxWait, RxPush, RxHold} rx_st_e;
  typedef enum logic [1:0] {TxIdle, TxIssue, TxWaitBusy, TxWaitIdle} tx_st_e;

  // ---------------- RX FIFO ----------------
  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RxAw-1:0] rx_wr_q, rx_rd_q;
  logic [RxCw-1:0] rx_cnt_q;
  logic            rx_full, rx_empty, rx_push_req, rx_push, rx_pop, rx_start;
  rx_st_e          rx_st_q;
  logic            read_op_q;

  assign rx_full     = (rx_cnt_q == RxCw'(RX_DEPTH));
  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_push_req = (rx_st_q == RxPush);
  assign rx_push     = rx_push_req && !rx_full;
  assign rx_pop      = bus.cpu_rx_pop && !rx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= bus.ser_data_read;
  end

  // ---------------- RX FSM ----------------
`ifdef SERIAL_FIFO_OVERRUN_EN
  assign rx_start = bus.ser_mode[1];
`else
  assign rx_start = bus.ser_mode[1] && !rx_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q   <= RxIdle;
      read_op_q <= 1'b0;
    end else begin
      case (rx_st_q)
        RxIdle: begin
          if (rx_start) begin
            rx_st_q   <= RxIssue;
            read_op_q <= 1'b1;
          end
        end
        RxIssue: begin
          read_op_q <= 1'b0;
          rx_st_q   <= RxWait;
        end
        RxWait:  rx_st_q <= RxPush;
        RxPush:  rx_st_q <= RxHold;
        // Leave only once the controller has cleared rx-ready, so a byte is never read twice.
        RxHold:  if (!bus.ser_mode[1]) rx_st_q <= RxIdle;
        default: rx_st_q <= RxIdle;
      endcase
    end
  end

`ifdef SERIAL_FIFO_OVERRUN_EN
  logic overrun_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (rx_push_req && rx_full) begin
      overrun_q <= 1'b1;
    end
  end
  assign bus.rx_overrun = overrun_q;
`else
  assign bus.rx_overrun = 1'b0;
`endif

  // ---------------- TX FIFO ----------------
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TxAw-1:0] tx_wr_q, tx_rd_q;
  logic [TxCw-1:0] tx_cnt_q;
  logic            tx_full, tx_empty, tx_push, tx_pop;
  tx_st_e          tx_st_q;
  logic            write_op_q;
  logic [7:0]      data_write_q;
  logic [TmrW-1:0] timer_q;

  assign tx_full  = (tx_cnt_q == TxCw'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = bus.cpu_tx_push && !tx_full;
  assign tx_pop   = (tx_st_q == TxIssue) && !tx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= bus.cpu_tx_data;
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q      <= TxIdle;
      write_op_q   <= 1'b0;
      data_write_q <= '0;
      timer_q      <= '0;
    end else begin
      unique case (tx_st_q)
        TxIdle: begin
          if (!tx_empty && bus.ser_mode[0]) begin
            tx_st_q      <= TxIssue;
            write_op_q   <= 1'b1;
            data_write_q <= tx_mem[tx_rd_q];
          end
        end
        TxIssue: begin
          write_op_q <= 1'b0;
          timer_q    <= '0;
          tx_st_q    <= TxWaitBusy;
        end
        // A controller that never reports busy is treated as having accepted the byte.
        TxWaitBusy: begin
          if (!bus.ser_mode[0]) begin
            tx_st_q <= TxWaitIdle;
          end else if (timer_q == TmrW'(BUSY_TIMEOUT - 1)) begin
            tx_st_q <= TxIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        TxWaitIdle: if (bus.ser_mode[0]) tx_st_q <= TxIdle;
        default:    tx_st_q <= TxIdle;
      endcase
    end
  end

  assign bus.cpu_rx_data    = rx_mem[rx_rd_q];
  assign bus.cpu_rx_valid   = !rx_empty;
  assign bus.cpu_tx_ready   = !tx_full;
  assign bus.rx_count       = rx_cnt_q;
  assign bus.tx_count       = tx_cnt_q;
  assign bus.ser_read_op    = read_op_q;
  assign bus.ser_write_op   = write_op_q;
  assign bus.ser_data_write = data_write_q;
endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Directed self-checking bench for serial_fifo_bridge with a small serial controller model.
module tb_serial_fifo_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode0, mode1;

  serial_fifo_bridge_if #(.RX_DEPTH(16), .TX_DEPTH(16)) bus ();

  serial_fifo_bridge #(
    .RX_DEPTH(16),
    .TX_DEPTH(16),
    .BUSY_TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.ser_mode = {mode1, mode0};

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Controller model and output monitors, all evaluated on the falling edge.
  int         cyc = 0;
  int         tx_sel = 0;   // 0: tx busy forever, 1: busy 10 cycles per write, 2: never busy
  int         busy_cnt = 0;
  int         wr_run = 0, max_wr_run = 0;
  int         rd_run = 0, max_rd_run = 0, rd_pulses = 0;
  logic [7:0] tx_seen[$];
  int         tx_cyc[$];

  initial begin
    mode0 = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.ser_write_op) begin
        wr_run++;
        if (wr_run == 1) begin
          tx_seen.push_back(bus.ser_data_write);
          tx_cyc.push_back(cyc);
        end
        if (wr_run > max_wr_run) max_wr_run = wr_run;
        busy_cnt = 10;
      end else begin
        wr_run = 0;
        if (busy_cnt > 0) busy_cnt--;
      end
      if (bus.ser_read_op) begin
        rd_run++;
        if (rd_run == 1) rd_pulses++;
        if (rd_run > max_rd_run) max_rd_run = rd_run;
      end else begin
        rd_run = 0;
      end
      case (tx_sel)
        0:       mode0 = 1'b0;
        1:       mode0 = (busy_cnt == 0);
        default: mode0 = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    bus.cpu_tx_push = 1'b1;
    bus.cpu_tx_data = b;
    tick();
    bus.cpu_tx_push = 1'b0;
  endtask

  task automatic pop_rx();
    bus.cpu_rx_pop = 1'b1;
    tick();
    bus.cpu_rx_pop = 1'b0;
  endtask

  // One controller receive: assert rx-ready, wait for read_op, clear rx-ready after the push.
  task automatic rx_xfer(input logic [7:0] b);
    int n;
    n = rd_pulses;
    mode1 = 1'b1;
    bus.ser_data_read = b;
    for (int k = 0; k < 20 && rd_pulses == n; k++) tick();
    check("rx_xfer_read_op", 32'(rd_pulses != n), 32'd1);
    repeat (3) tick();
    mode1 = 1'b0;
    repeat (2) tick();
  endtask

  typedef struct {
    logic [7:0] rx_in;
    logic [7:0] tx_in;
    logic [7:0] exp_rx;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{rx_in: 8'hA5, tx_in: 8'h3C, exp_rx: 8'hA5, exp_tx: 8'h3C};
    vecs[1] = '{rx_in: 8'h00, tx_in: 8'hFF, exp_rx: 8'h00, exp_tx: 8'hFF};
    vecs[2] = '{rx_in: 8'hFF, tx_in: 8'h00, exp_rx: 8'hFF, exp_tx: 8'h00};
    vecs[3] = '{rx_in: 8'h81, tx_in: 8'h7E, exp_rx: 8'h81, exp_tx: 8'h7E};

    bus.cpu_rx_pop    = 1'b0;
    bus.cpu_tx_push   = 1'b0;
    bus.cpu_tx_data   = 8'h00;
    bus.ser_data_read = 8'h00;
    mode1 = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst_rx_valid", 32'(bus.cpu_rx_valid), 32'd0);
    check("rst_tx_ready", 32'(bus.cpu_tx_ready), 32'd1);
    check("rst_read_op", 32'(bus.ser_read_op), 32'd0);
    check("rst_write_op", 32'(bus.ser_write_op), 32'd0);
    check("rst_data_write", 32'(bus.ser_data_write), 32'd0);
    check("rst_rx_count", 32'(bus.rx_count), 32'd0);
    check("rst_tx_count", 32'(bus.tx_count), 32'd0);
    check("rst_overrun", 32'(bus.rx_overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // RX single byte with latency and no double read
    n = rd_pulses;
    mode1 = 1'b1;
    bus.ser_data_read = 8'h5A;
    for (int k = 0; k < 20 && rd_pulses == n; k++) tick();
    check("rx1_read_op_seen", 32'(rd_pulses != n), 32'd1);
    tick();
    tick();
    check("rx1_valid_before_3", 32'(bus.cpu_rx_valid), 32'd0);
    tick();
    check("rx1_valid_at_3", 32'(bus.cpu_rx_valid), 32'd1);
    repeat (3) tick();
    mode1 = 1'b0;
    repeat (3) tick();
    check("rx1_single_read", 32'(rd_pulses - n), 32'd1);
    check("rx1_pulse_width", 32'(max_rd_run), 32'd1);
    check("rx1_data", 32'(bus.cpu_rx_data), 32'h5A);
    check("rx1_count", 32'(bus.rx_count), 32'd1);
    pop_rx();
    check("rx1_count_after_pop", 32'(bus.rx_count), 32'd0);
    check("rx1_valid_after_pop", 32'(bus.cpu_rx_valid), 32'd0);

    // Table: one RX byte and one TX byte per vector, both paths running together
    tx_sel = 1;
    tick();
    tx_seen.delete();
    for (int i = 0; i < 4; i++) begin
      push_tx(vecs[i].tx_in);
      rx_xfer(vecs[i].rx_in);
      check("vec_rx_data", 32'(bus.cpu_rx_data), 32'(vecs[i].exp_rx));
      pop_rx();
      for (int k = 0; k < 40 && tx_seen.size() < i + 1; k++) tick();
      check("vec_tx_count_seen", 32'(tx_seen.size()), 32'(i + 1));
      if (tx_seen.size() > i) check("vec_tx_data", 32'(tx_seen[i]), 32'(vecs[i].exp_tx));
    end
    repeat (15) tick();

    // TX burst with busy model: one write per idle window, 12 cycles apart
    tx_seen.delete();
    tx_cyc.delete();
    max_wr_run = 0;
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    for (int k = 0; k < 100 && tx_seen.size() < 3; k++) tick();
    check("burst_count", 32'(tx_seen.size()), 32'd3);
    if (tx_seen.size() == 3) begin
      check("burst_b0", 32'(tx_seen[0]), 32'h11);
      check("burst_b1", 32'(tx_seen[1]), 32'h22);
      check("burst_b2", 32'(tx_seen[2]), 32'h33);
      check("burst_gap01", 32'(tx_cyc[1] - tx_cyc[0]), 32'd12);
      check("burst_gap12", 32'(tx_cyc[2] - tx_cyc[1]), 32'd12);
    end
    check("burst_pulse_width", 32'(max_wr_run), 32'd1);
    repeat (5) tick();
    check("burst_data_hold", 32'(bus.ser_data_write), 32'h33);
    repeat (15) tick();

    // TX full and wrap: 17 pushes while the controller stays busy
    tx_sel = 0;
    repeat (2) tick();
    tx_seen.delete();
    for (int i = 0; i < 17; i++) push_tx(8'h40 + 8'(i));
    check("full_tx_count", 32'(bus.tx_count), 32'd16);
    check("full_tx_ready", 32'(bus.cpu_tx_ready), 32'd0);
    check("full_no_write", 32'(tx_seen.size()), 32'd0);
    tx_sel = 1;
    for (int k = 0; k < 400 && tx_seen.size() < 16; k++) tick();
    repeat (30) tick();
    check("drain_count", 32'(tx_seen.size()), 32'd16);
    for (int i = 0; i < 16 && i < tx_seen.size(); i++) begin
      check("drain_order", 32'(tx_seen[i]), 32'h40 + 32'(i));
    end
    check("drain_tx_count", 32'(bus.tx_count), 32'd0);

    // Busy timeout: controller never reports busy
    tx_sel = 2;
    repeat (3) tick();
    tx_seen.delete();
    tx_cyc.delete();
    push_tx(8'hA1);
    push_tx(8'hA2);
    for (int k = 0; k < 40 && tx_seen.size() < 2; k++) tick();
    check("timeout_count", 32'(tx_seen.size()), 32'd2);
    if (tx_seen.size() == 2) begin
      check("timeout_b1", 32'(tx_seen[1]), 32'hA2);
      check("timeout_gap", 32'(tx_cyc[1] - tx_cyc[0]), 32'd6);
    end
    repeat (10) tick();

    // RX full: backpressure (default) or drop with overrun flag
    for (int i = 0; i < 16; i++) rx_xfer(8'hC0 + 8'(i));
    check("rxfull_count", 32'(bus.rx_count), 32'd16);
    n = rd_pulses;
    mode1 = 1'b1;
    bus.ser_data_read = 8'hEE;
`ifdef SERIAL_FIFO_OVERRUN_EN
    for (int k = 0; k < 20 && rd_pulses == n; k++) tick();
    check("ovr_read_seen", 32'(rd_pulses != n), 32'd1);
    repeat (3) tick();
    mode1 = 1'b0;
    repeat (2) tick();
    check("ovr_flag", 32'(bus.rx_overrun), 32'd1);
    check("ovr_count", 32'(bus.rx_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("ovr_drain", 32'(bus.cpu_rx_data), 32'hC0 + 32'(i));
      pop_rx();
    end
    check("ovr_flag_sticky", 32'(bus.rx_overrun), 32'd1);
`else
    repeat (8) tick();
    check("bp_no_read", 32'(rd_pulses - n), 32'd0);
    check("bp_no_overrun", 32'(bus.rx_overrun), 32'd0);
    pop_rx();
    for (int k = 0; k < 20 && rd_pulses == n; k++) tick();
    check("bp_read_after_pop", 32'(rd_pulses - n), 32'd1);
    repeat (3) tick();
    mode1 = 1'b0;
    repeat (2) tick();
    check("bp_count", 32'(bus.rx_count), 32'd16);
    for (int i = 1; i < 16; i++) begin
      check("bp_drain", 32'(bus.cpu_rx_data), 32'hC0 + 32'(i));
      pop_rx();
    end
    check("bp_last", 32'(bus.cpu_rx_data), 32'hEE);
    pop_rx();
`endif
    check("rx_empty_end", 32'(bus.cpu_rx_valid), 32'd0);

    // Asynchronous reset in the middle of a TX write
    tx_sel = 1;
    rx_xfer(8'h77);
    check("prerst_rx_valid", 32'(bus.cpu_rx_valid), 32'd1);
    push_tx(8'hB1);
    push_tx(8'hB2);
    push_tx(8'hB3);
    for (int k = 0; k < 40 && !bus.ser_write_op; k++) tick();
    check("prerst_write_op", 32'(bus.ser_write_op), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_write_op", 32'(bus.ser_write_op), 32'd0);
    check("arst_tx_count", 32'(bus.tx_count), 32'd0);
    check("arst_tx_ready", 32'(bus.cpu_tx_ready), 32'd1);
    check("arst_data_write", 32'(bus.ser_data_write), 32'd0);
    check("arst_rx_valid", 32'(bus.cpu_rx_valid), 32'd0);
    check("arst_rx_count", 32'(bus.rx_count), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("postrst_write_op", 32'(bus.ser_write_op), 32'd0);
    check("postrst_tx_count", 32'(bus.tx_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
